spi_px_arbiter: RTL and testbench
=================================

# spi_px_arbiter

Shares the single SPI pixel channel between the gray/sobel pipeline and the LFSR configuration path. It replaces the static combinational steering of the SPI receive and transmit words with a registered router on the receive side. On the transmit side it provides per-source 2-entry buffers and a round-robin arbiter. It sits between `spi_control` and the `top_gray_sobel` / `LFSR` instances. Mode changes happen only at a quiescent point, so no in-flight word is lost or misrouted.

## Interface
Parameters:
- PIXEL_BITS, 24, width of every pixel/config word
- FIFO_DEPTH, 2, entries per transmit-source buffer (power of two, ≥2)

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- mode_req_i  in  1  requested path: 0 = gray/sobel, 1 = LFSR
- mode_o  out  1  active path
- switch_pending_o  out  1  mode_req_i ≠ mode_o, waiting for quiescence
- spi_rx_rdy_i  in  1  one-cycle pulse: SPI received a word
- spi_rx_data_i  in  PIXEL_BITS  received word
- px_rdy_o / px_o  out  1 / PIXEL_BITS  word to gray/sobel
- cfg_rdy_o / cfg_data_o  out  1 / PIXEL_BITS  word to LFSR
- px_done_i / px_res_i  in  1 / PIXEL_BITS  result pulse from gray/sobel
- cfg_done_i / cfg_res_i  in  1 / PIXEL_BITS  result pulse from LFSR
- spi_tx_ready_i  in  1  SPI can accept a transmit word this cycle
- spi_tx_rdy_o / spi_tx_data_o  out  1 / PIXEL_BITS  transmit word pulse to SPI
- overflow_o  out  1  sticky: a result was dropped because its buffer was full

## Operation
- Reset values:
  - mode_o = 0; switch_pending_o = 0; overflow_o = 0.
  - All rdy outputs = 0; all data outputs = 0.
  - Both buffers empty; round-robin pointer favours px.
- Receive routing (registered):
  - On spi_rx_rdy_i, the word goes to px_o/px_rdy_o if mode_o = 0, else to cfg_data_o/cfg_rdy_o.
  - The non-selected rdy stays 0.
  - Data outputs hold their last value when rdy = 0.
- Transmit buffers: one FIFO per source, pushed on px_done_i / cfg_done_i.
  - Push and pop on the same FIFO in the same cycle is allowed; count is unchanged.
  - Push into a full FIFO with no simultaneous pop: the word is dropped and overflow_o is set. overflow_o clears only on reset.
  - Results are accepted from both sources regardless of mode_o, so late results after a switch still drain.
- Arbiter: when spi_tx_ready_i = 1 and at least one FIFO is non-empty, exactly one FIFO is popped.
  - If both are non-empty, the source not granted last wins. The pointer updates only on a grant.
  - If only one is non-empty, that source is granted; the pointer still updates.
- Mode state machine, states ACTIVE and DRAIN:
  - ACTIVE → DRAIN when mode_req_i ≠ mode_o.
  - DRAIN → ACTIVE, toggling mode_o, in the first cycle with: both FIFOs empty, no push, no pop, no spi_rx_rdy_i.
  - DRAIN → ACTIVE without toggling if mode_req_i returns to mode_o.
  - During DRAIN, received words still route by the old mode_o.
  - switch_pending_o = 1 exactly in DRAIN.

## Timing
- Receive latency: spi_rx_rdy_i sampled at edge E → px_rdy_o/cfg_rdy_o high for the one cycle after E.
- Transmit latency:
  - A result pushed at edge E is poppable at edge E+1.
  - spi_tx_rdy_o and spi_tx_data_o are registered and high for the one cycle following the pop edge.
  - Minimum result-to-SPI latency is 2 cycles.
- Throughput: one transmit word per cycle while spi_tx_ready_i = 1.
- mode_o changes at the edge ending the qualifying quiescent cycle. The first word routed by the new mode is sampled on the next edge.
- Reset assertion mid-transfer clears FIFOs, pulses and mode immediately; no output pulse after reset release without new input.

## Test plan
- Reset mid-stream: with buffers holding 2 words and overflow_o = 1, assert reset_i → all outputs 0, mode_o = 0, FIFOs empty; after release, no spi_tx_rdy_o without new results.
- Receive routing: mode 0, rx word 0xA5A5A5 → px_rdy_o pulse with px_o = 0xA5A5A5 one cycle later, cfg_rdy_o stays 0. Switch to mode 1 and repeat with 0x123456 → only cfg path pulses.
- Round-robin: hold spi_tx_ready_i = 0, push px 0x000001, 0x000002 and cfg 0x100001, 0x100002, then raise ready → SPI order 0x000001, 0x100001, 0x000002, 0x100002 on 4 consecutive cycles.
- Overflow: ready = 0, three px_done_i pulses (0x11, 0x22, 0x33) → overflow_o = 1; drain yields 0x11, 0x22 only.
- Mode switch with traffic: request mode 1 while the px FIFO holds 1 word and spi_tx_ready_i = 0 → switch_pending_o = 1, mode_o stays 0. Raise ready → word transmitted, then mode_o = 1 one quiescent cycle later.
- Request withdrawn: raise then lower mode_req_i during DRAIN → return to ACTIVE, mode_o unchanged.

Source files
------------

// File: rtl/spi_px_arbiter_if.sv
// Bundle of the SPI pixel-channel signals shared between spi_control,
// the gray/sobel pipeline and the LFSR configuration path.
interface spi_px_arbiter_if #(
    parameter int PIXEL_BITS = 24
);
    logic                  mode_req_i;
    logic                  mode_o;
    logic                  switch_pending_o;
    logic                  spi_rx_rdy_i;
    logic [PIXEL_BITS-1:0] spi_rx_data_i;
    logic                  px_rdy_o;
    logic [PIXEL_BITS-1:0] px_o;
    logic                  cfg_rdy_o;
    logic [PIXEL_BITS-1:0] cfg_data_o;
    logic                  px_done_i;
    logic [PIXEL_BITS-1:0] px_res_i;
    logic                  cfg_done_i;
    logic [PIXEL_BITS-1:0] cfg_res_i;
    logic                  spi_tx_ready_i;
    logic                  spi_tx_rdy_o;
    logic [PIXEL_BITS-1:0] spi_tx_data_o;
    logic                  overflow_o;

    // Arbiter side
    modport slave (
        input  mode_req_i, spi_rx_rdy_i, spi_rx_data_i,
               px_done_i, px_res_i, cfg_done_i, cfg_res_i, spi_tx_ready_i,
        output mode_o, switch_pending_o, px_rdy_o, px_o, cfg_rdy_o, cfg_data_o,
               spi_tx_rdy_o, spi_tx_data_o, overflow_o
    );

    // Driver side (SPI controller / sources / bench)
    modport master (
        output mode_req_i, spi_rx_rdy_i, spi_rx_data_i,
               px_done_i, px_res_i, cfg_done_i, cfg_res_i, spi_tx_ready_i,
        input  mode_o, switch_pending_o, px_rdy_o, px_o, cfg_rdy_o, cfg_data_o,
               spi_tx_rdy_o, spi_tx_data_o, overflow_o
    );
endinterface

// File: rtl/spi_px_arbiter.sv
// SPI pixel channel sharer: registered receive router, per-source transmit
// FIFOs with round-robin arbitration, and a mode FSM that only switches
// paths once the channel is quiescent.

// Small power-of-two FIFO, one per transmit source.
module spi_px_arbiter_fifo #(
    parameter int PIXEL_BITS = 24,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [PIXEL_BITS-1:0] i_wdata,
    output logic [PIXEL_BITS-1:0] o_rdata,
    output logic                  o_empty,
    output logic                  o_drop
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [PIXEL_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic                  w_full;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push && (!w_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;
    assign o_drop    = i_push && w_full && !i_pop;
    assign o_rdata   = r_mem[r_rptr];

    // Storage write; contents are don't-care while the count says empty.
    always_ff @(posedge clk_i) begin
        if (w_do_push)
            r_mem[r_wptr] <= i_wdata;
    end

    // Pointer and occupancy tracking; pointers wrap on the power-of-two depth.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - 1'b1;
        end
    end
endmodule

module spi_px_arbiter #(
    parameter int PIXEL_BITS = 24,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    spi_px_arbiter_if.slave   bus
);
    localparam int NSRC    = 2;
    localparam int SRC_PX  = 0;
    localparam int SRC_CFG = 1;

    localparam logic [0:0] ST_ACTIVE = 1'b0;
    localparam logic [0:0] ST_DRAIN  = 1'b1;

    logic [NSRC-1:0]                 w_push;
    logic [NSRC-1:0]                 w_pop;
    logic [NSRC-1:0]                 w_empty;
    logic [NSRC-1:0]                 w_drop;
    logic [NSRC-1:0][PIXEL_BITS-1:0] w_wdata;
    logic [NSRC-1:0][PIXEL_BITS-1:0] w_rdata;

    logic                  w_gnt_vld;
    logic                  w_gnt_cfg;
    logic                  w_quiet;

    logic [0:0]            r_state;
    logic                  r_mode;
    logic                  r_last_cfg;
    logic                  r_px_rdy;
    logic [PIXEL_BITS-1:0] r_px;
    logic                  r_cfg_rdy;
    logic [PIXEL_BITS-1:0] r_cfg;
    logic                  r_tx_rdy;
    logic [PIXEL_BITS-1:0] r_tx_data;
    logic                  r_overflow;

    // Results are buffered from both sources regardless of mode so late
    // results after a switch still drain.
    assign w_push[SRC_PX]   = bus.px_done_i;
    assign w_push[SRC_CFG]  = bus.cfg_done_i;
    assign w_wdata[SRC_PX]  = bus.px_res_i;
    assign w_wdata[SRC_CFG] = bus.cfg_res_i;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        spi_px_arbiter_fifo #(
            .PIXEL_BITS (PIXEL_BITS),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_wdata (w_wdata[g]),
            .o_rdata (w_rdata[g]),
            .o_empty (w_empty[g]),
            .o_drop  (w_drop[g])
        );
    end

    // Round-robin grant: with both pending, the source not granted last wins.
    always_comb begin
        w_gnt_vld = bus.spi_tx_ready_i && (w_empty != {NSRC{1'b1}});
        if (!w_empty[SRC_PX] && !w_empty[SRC_CFG])
            w_gnt_cfg = !r_last_cfg;
        else
            w_gnt_cfg = !w_empty[SRC_CFG];
        w_pop          = '0;
        w_pop[SRC_CFG] = w_gnt_vld && w_gnt_cfg;
        w_pop[SRC_PX]  = w_gnt_vld && !w_gnt_cfg;
    end

    // Transmit word register and round-robin pointer (starts favouring px).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_tx_rdy   <= 1'b0;
            r_tx_data  <= '0;
            r_last_cfg <= 1'b1;
        end else begin
            r_tx_rdy <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_tx_data  <= w_rdata[w_gnt_cfg];
                r_last_cfg <= w_gnt_cfg;
            end
        end
    end

    // Receive router: steer by the current (old, while draining) mode.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_px_rdy  <= 1'b0;
            r_px      <= '0;
            r_cfg_rdy <= 1'b0;
            r_cfg     <= '0;
        end else begin
            r_px_rdy  <= bus.spi_rx_rdy_i && !r_mode;
            r_cfg_rdy <= bus.spi_rx_rdy_i && r_mode;
            if (bus.spi_rx_rdy_i && !r_mode)
                r_px <= bus.spi_rx_data_i;
            if (bus.spi_rx_rdy_i && r_mode)
                r_cfg <= bus.spi_rx_data_i;
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_overflow <= 1'b0;
        else if (|w_drop)
            r_overflow <= 1'b1;
    end

    // Quiescent: nothing buffered, nothing entering, nothing leaving.
    assign w_quiet = (&w_empty) && !(|w_push) && !(|w_pop) && !bus.spi_rx_rdy_i;

    // Mode FSM: a withdrawn request wins over a pending switch.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_ACTIVE;
            r_mode  <= 1'b0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    if (bus.mode_req_i != r_mode)
                        r_state <= ST_DRAIN;
                end
                default: begin
                    if (bus.mode_req_i == r_mode) begin
                        r_state <= ST_ACTIVE;
                    end else if (w_quiet) begin
                        r_state <= ST_ACTIVE;
                        r_mode  <= !r_mode;
                    end
                end
            endcase
        end
    end

    assign bus.mode_o           = r_mode;
    assign bus.switch_pending_o = (r_state == ST_DRAIN);
    assign bus.px_rdy_o         = r_px_rdy;
    assign bus.px_o             = r_px;
    assign bus.cfg_rdy_o        = r_cfg_rdy;
    assign bus.cfg_data_o       = r_cfg;
    assign bus.spi_tx_rdy_o     = r_tx_rdy;
    assign bus.spi_tx_data_o    = r_tx_data;
    assign bus.overflow_o       = r_overflow;
endmodule

// File: tb/tb_spi_px_arbiter.sv
// Directed bench for spi_px_arbiter: vector table plus hand sequences for
// overflow, mode switch with traffic, withdrawn request and mid-stream reset.
module tb_spi_px_arbiter;
    localparam int PB = 24;

    typedef struct {
        logic          req;
        logic          rx;
        logic [PB-1:0] rxd;
        logic          pd;
        logic [PB-1:0] pr;
        logic          cd;
        logic [PB-1:0] cr;
        logic          rdy;
    } in_t;

    typedef struct {
        logic          prdy;
        logic [PB-1:0] px;
        logic          crdy;
        logic [PB-1:0] cfg;
        logic          trdy;
        logic [PB-1:0] txd;
        logic          mode;
        logic          pend;
        logic          ovf;
    } out_t;

    typedef struct {
        string nm;
        in_t   i;
        out_t  o;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    spi_px_arbiter_if #(.PIXEL_BITS(PB)) bus ();

    spi_px_arbiter #(.PIXEL_BITS(PB), .FIFO_DEPTH(2)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(logic req, logic rx, logic [PB-1:0] rxd,
                                  logic pd, logic [PB-1:0] pr,
                                  logic cd, logic [PB-1:0] cr, logic rdy);
        in_t v;
        v.req = req; v.rx = rx; v.rxd = rxd; v.pd = pd; v.pr = pr;
        v.cd = cd; v.cr = cr; v.rdy = rdy;
        return v;
    endfunction

    function automatic out_t mk_out(logic prdy, logic [PB-1:0] px,
                                    logic crdy, logic [PB-1:0] cfg,
                                    logic trdy, logic [PB-1:0] txd,
                                    logic mode, logic pend, logic ovf);
        out_t v;
        v.prdy = prdy; v.px = px; v.crdy = crdy; v.cfg = cfg;
        v.trdy = trdy; v.txd = txd; v.mode = mode; v.pend = pend; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h exp=%h", nm, fld, act, exp);
        end
    endtask

    task automatic check_out(string nm, out_t e);
        chk(nm, "px_rdy",  32'(bus.px_rdy_o),         32'(e.prdy));
        chk(nm, "px",      32'(bus.px_o),             32'(e.px));
        chk(nm, "cfg_rdy", 32'(bus.cfg_rdy_o),        32'(e.crdy));
        chk(nm, "cfg",     32'(bus.cfg_data_o),       32'(e.cfg));
        chk(nm, "tx_rdy",  32'(bus.spi_tx_rdy_o),     32'(e.trdy));
        chk(nm, "tx_data", 32'(bus.spi_tx_data_o),    32'(e.txd));
        chk(nm, "mode",    32'(bus.mode_o),           32'(e.mode));
        chk(nm, "pending", 32'(bus.switch_pending_o), 32'(e.pend));
        chk(nm, "ovf",     32'(bus.overflow_o),       32'(e.ovf));
    endtask

    task automatic drive(in_t v);
        bus.mode_req_i     = v.req;
        bus.spi_rx_rdy_i   = v.rx;
        bus.spi_rx_data_i  = v.rxd;
        bus.px_done_i      = v.pd;
        bus.px_res_i       = v.pr;
        bus.cfg_done_i     = v.cd;
        bus.cfg_res_i      = v.cr;
        bus.spi_tx_ready_i = v.rdy;
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(string nm, in_t i, out_t o);
        drive(i);
        @(posedge clk);
        #1;
        check_out(nm, o);
    endtask

    vec_t tbl [19];
    out_t zero_o;
    in_t  idle_i;

    initial begin
        zero_o = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_i = mk_in(0, 0, 0, 0, 0, 0, 0, 0);

        // Receive routing, mode switch 0->1, round-robin, push+pop same cycle.
        tbl[0]  = '{"rx_px",    mk_in(0,1,24'hA5A5A5,0,0,0,0,0),     mk_out(1,24'hA5A5A5,0,0,0,0,0,0,0)};
        tbl[1]  = '{"rx_idle",  mk_in(0,0,0,0,0,0,0,0),              mk_out(0,24'hA5A5A5,0,0,0,0,0,0,0)};
        tbl[2]  = '{"req1",     mk_in(1,0,0,0,0,0,0,0),              mk_out(0,24'hA5A5A5,0,0,0,0,0,1,0)};
        tbl[3]  = '{"drain_q",  mk_in(1,0,0,0,0,0,0,0),              mk_out(0,24'hA5A5A5,0,0,0,0,1,0,0)};
        tbl[4]  = '{"rx_cfg",   mk_in(1,1,24'h123456,0,0,0,0,0),     mk_out(0,24'hA5A5A5,1,24'h123456,0,0,1,0,0)};
        tbl[5]  = '{"idle1",    mk_in(1,0,0,0,0,0,0,0),              mk_out(0,24'hA5A5A5,0,24'h123456,0,0,1,0,0)};
        tbl[6]  = '{"push_p1",  mk_in(1,0,0,1,24'h000001,0,0,0),     mk_out(0,24'hA5A5A5,0,24'h123456,0,0,1,0,0)};
        tbl[7]  = '{"push_p2",  mk_in(1,0,0,1,24'h000002,0,0,0),     mk_out(0,24'hA5A5A5,0,24'h123456,0,0,1,0,0)};
        tbl[8]  = '{"push_c1",  mk_in(1,0,0,0,0,1,24'h100001,0),     mk_out(0,24'hA5A5A5,0,24'h123456,0,0,1,0,0)};
        tbl[9]  = '{"push_c2",  mk_in(1,0,0,0,0,1,24'h100002,0),     mk_out(0,24'hA5A5A5,0,24'h123456,0,0,1,0,0)};
        tbl[10] = '{"rr0",      mk_in(1,0,0,0,0,0,0,1),              mk_out(0,24'hA5A5A5,0,24'h123456,1,24'h000001,1,0,0)};
        tbl[11] = '{"rr1",      mk_in(1,0,0,0,0,0,0,1),              mk_out(0,24'hA5A5A5,0,24'h123456,1,24'h100001,1,0,0)};
        tbl[12] = '{"rr2",      mk_in(1,0,0,0,0,0,0,1),              mk_out(0,24'hA5A5A5,0,24'h123456,1,24'h000002,1,0,0)};
        tbl[13] = '{"rr3",      mk_in(1,0,0,0,0,0,0,1),              mk_out(0,24'hA5A5A5,0,24'h123456,1,24'h100002,1,0,0)};
        tbl[14] = '{"rr_empty", mk_in(1,0,0,0,0,0,0,1),              mk_out(0,24'hA5A5A5,0,24'h123456,0,24'h100002,1,0,0)};
        tbl[15] = '{"push55",   mk_in(1,0,0,1,24'h000055,0,0,1),     mk_out(0,24'hA5A5A5,0,24'h123456,0,24'h100002,1,0,0)};
        tbl[16] = '{"pushpop",  mk_in(1,0,0,1,24'h000066,0,0,1),     mk_out(0,24'hA5A5A5,0,24'h123456,1,24'h000055,1,0,0)};
        tbl[17] = '{"pop66",    mk_in(1,0,0,0,0,0,0,1),              mk_out(0,24'hA5A5A5,0,24'h123456,1,24'h000066,1,0,0)};
        tbl[18] = '{"idle2",    mk_in(1,0,0,0,0,0,0,0),              mk_out(0,24'hA5A5A5,0,24'h123456,0,24'h000066,1,0,0)};

        drive(idle_i);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", zero_o);
        rst = 1'b0;

        for (int k = 0; k < 19; k++)
            step(tbl[k].nm, tbl[k].i, tbl[k].o);

        // Overflow: third push into a full px FIFO is dropped.
        step("ovf_p1", mk_in(1,0,0,1,24'h11,0,0,0), mk_out(0,24'hA5A5A5,0,24'h123456,0,24'h66,1,0,0));
        step("ovf_p2", mk_in(1,0,0,1,24'h22,0,0,0), mk_out(0,24'hA5A5A5,0,24'h123456,0,24'h66,1,0,0));
        step("ovf_p3", mk_in(1,0,0,1,24'h33,0,0,0), mk_out(0,24'hA5A5A5,0,24'h123456,0,24'h66,1,0,1));
        step("ovf_d1", mk_in(1,0,0,0,0,0,0,1),      mk_out(0,24'hA5A5A5,0,24'h123456,1,24'h11,1,0,1));
        step("ovf_d2", mk_in(1,0,0,0,0,0,0,1),      mk_out(0,24'hA5A5A5,0,24'h123456,1,24'h22,1,0,1));
        step("ovf_d3", mk_in(1,0,0,0,0,0,0,1),      mk_out(0,24'hA5A5A5,0,24'h123456,0,24'h22,1,0,1));

        // Mode switch 1->0 while the cfg FIFO holds a word.
        step("sw_push",  mk_in(1,0,0,0,0,1,24'h77,0),     mk_out(0,24'hA5A5A5,0,24'h123456,0,24'h22,1,0,1));
        step("sw_req0",  mk_in(0,0,0,0,0,0,0,0),          mk_out(0,24'hA5A5A5,0,24'h123456,0,24'h22,1,1,1));
        step("sw_rxold", mk_in(0,1,24'hABCDEF,0,0,0,0,0), mk_out(0,24'hA5A5A5,1,24'hABCDEF,0,24'h22,1,1,1));
        step("sw_pop",   mk_in(0,0,0,0,0,0,0,1),          mk_out(0,24'hA5A5A5,0,24'hABCDEF,1,24'h77,1,1,1));
        step("sw_quiet", mk_in(0,0,0,0,0,0,0,1),          mk_out(0,24'hA5A5A5,0,24'hABCDEF,0,24'h77,0,0,1));
        step("sw_rxnew", mk_in(0,1,24'h424242,0,0,0,0,0), mk_out(1,24'h424242,0,24'hABCDEF,0,24'h77,0,0,1));

        // Request raised then withdrawn during DRAIN.
        step("wd_req1", mk_in(1,0,0,0,0,0,0,0), mk_out(0,24'h424242,0,24'hABCDEF,0,24'h77,0,1,1));
        step("wd_req0", mk_in(0,0,0,0,0,0,0,0), mk_out(0,24'h424242,0,24'hABCDEF,0,24'h77,0,0,1));
        step("wd_hold", mk_in(0,0,0,0,0,0,0,0), mk_out(0,24'h424242,0,24'hABCDEF,0,24'h77,0,0,1));

        // Reset mid-stream: mode 1, px FIFO full, overflow set, cfg pulse live.
        step("rs_req1", mk_in(1,0,0,0,0,0,0,0),           mk_out(0,24'h424242,0,24'hABCDEF,0,24'h77,0,1,1));
        step("rs_sw",   mk_in(1,0,0,0,0,0,0,0),           mk_out(0,24'h424242,0,24'hABCDEF,0,24'h77,1,0,1));
        step("rs_p1",   mk_in(1,0,0,1,24'hA1,0,0,0),      mk_out(0,24'h424242,0,24'hABCDEF,0,24'h77,1,0,1));
        step("rs_p2",   mk_in(1,0,0,1,24'hA2,0,0,0),      mk_out(0,24'h424242,0,24'hABCDEF,0,24'h77,1,0,1));
        step("rs_p3",   mk_in(1,1,24'h5A5A5A,1,24'hA3,0,0,0), mk_out(0,24'h424242,1,24'h5A5A5A,0,24'h77,1,0,1));
        #2;
        rst = 1'b1;
        #1;
        check_out("rs_async", zero_o);
        drive(mk_in(0,0,0,0,0,0,0,1));
        @(posedge clk);
        #1;
        check_out("rs_held", zero_o);
        rst = 1'b0;
        for (int k = 0; k < 4; k++)
            step("rs_nopulse", mk_in(0,0,0,0,0,0,0,1), zero_o);
        step("rs_push",  mk_in(0,0,0,1,24'hB1,0,0,1), zero_o);
        step("rs_pop",   mk_in(0,0,0,0,0,0,0,1),      mk_out(0,0,0,0,1,24'hB1,0,0,0));
        step("rs_empty", mk_in(0,0,0,0,0,0,0,1),      mk_out(0,0,0,0,0,24'hB1,0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
